button_irq_ctrl: RTL

//  Memory-mapped controller for NUM_BTN push-buttons on the CPU peripheral bus.

---
 rtl/button_irq_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/button_irq_ctrl.sv
// button_irq_ctrl
//   Memory-mapped controller for NUM_BTN push-buttons on the CPU peripheral bus.
//   Each raw button input is brought into the clk domain by a 2-flop
//   synchroniser, then debounced: a new level is accepted only after it has
//   been held for DB_LIMIT consecutive cycles. Every debounced press
//   (0->1 edge) sets a sticky event bit that software clears by writing 1.
//   A registered, maskable interrupt is raised while any enabled event is pending.
//
//   Register map (byte addresses, 32-bit words):
//     BASE_ADDR+0  LEVEL  RO   debounced button levels
//     BASE_ADDR+4  EVENT  W1C  sticky press events
//     BASE_ADDR+8  MASK   RW   interrupt enables
//   Unmapped addresses read 0 and ignore writes; bits 31:NUM_BTN read 0.
//
// Ports
//   clk     in   1        system clock, rising edge
//   rst     in   1        asynchronous reset, active-high
//   addr    in   32       bus byte address
//   we      in   1        bus write strobe, sampled on rising clk edge
//   wdata   in   32       bus write data
//   button  in   NUM_BTN  raw asynchronous button inputs, 1 = pressed
//   rdata   out  32       bus read data, combinational from addr
//   irq     out  1        interrupt request, level, registered
module button_irq_ctrl #(
    parameter int          NUM_BTN   = 5,
    parameter int          DB_LIMIT  = 1_000_000,
    parameter int          DB_W      = 20,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F078
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr,
    input  logic               we,
    input  logic [31:0]        wdata,
    input  logic [NUM_BTN-1:0] button,
    output logic [31:0]        rdata,
    output logic               irq
);

    localparam logic [31:0]     LEVEL_ADDR = BASE_ADDR;
    localparam logic [31:0]     EVENT_ADDR = BASE_ADDR + 32'd4;
    localparam logic [31:0]     MASK_ADDR  = BASE_ADDR + 32'd8;
    localparam logic [DB_W-1:0] CNT_LAST   = DB_W'(DB_LIMIT - 1);
    localparam logic [DB_W-1:0] CNT_ONE    = DB_W'(1);

    logic [NUM_BTN-1:0] sync_p0;
    logic [NUM_BTN-1:0] sync_p1;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_next;
    logic [NUM_BTN-1:0] evt;
    logic [NUM_BTN-1:0] evt_next;
    logic [NUM_BTN-1:0] mask;
    logic [NUM_BTN-1:0] mask_next;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] w1c;
    logic [DB_W-1:0]    cnt      [NUM_BTN];
    logic [DB_W-1:0]    cnt_next [NUM_BTN];

    // Only wdata[NUM_BTN-1:0] is architecturally meaningful.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // Debounce: count consecutive cycles the synchronised input disagrees with
    // the accepted level; any agreement restarts the count from zero.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            level_next[i] = level[i];
            cnt_next[i]   = '0;
            if (sync_p1[i] != level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    level_next[i] = sync_p1[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // A press landing in the same cycle as a W1C of that bit keeps the event set.
    assign press     = level_next & ~level;
    assign w1c       = (we && (addr == EVENT_ADDR)) ? wdata[NUM_BTN-1:0] : '0;
    assign evt_next  = (evt & ~w1c) | press;
    assign mask_next = (we && (addr == MASK_ADDR)) ? wdata[NUM_BTN-1:0] : mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            level   <= '0;
            evt     <= '0;
            mask    <= '0;
            irq     <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // stage p0 -> p1: two-flop synchroniser
            sync_p0 <= button;
            sync_p1 <= sync_p0;
            // debounced level, events, mask and irq update together
            level   <= level_next;
            evt     <= evt_next;
            mask    <= mask_next;
            irq     <= |(evt_next & mask_next);
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            LEVEL_ADDR: rdata[NUM_BTN-1:0] = level;
            EVENT_ADDR: rdata[NUM_BTN-1:0] = evt;
            MASK_ADDR:  rdata[NUM_BTN-1:0] = mask;
            default:    rdata = '0;
        endcase
    end

endmodule
